// File: rtl/axi_stream_source.sv
// AXI-Stream packet source: deterministic beat sequence, stable under backpressure, done_out after NUM_PACKETS.
// Optional: define AXIS_SOURCE_RANDOM_VALID_EN to randomly withhold tvalid between beats.
module axi_stream_source #(
  parameter int                     TDATA_WIDTH = 16,
  parameter int                     TID_WIDTH   = 1,
  parameter int                     TDEST_WIDTH = 1,
  parameter int                     TUSER_WIDTH = 1,
  parameter int                     USE_TLAST   = 0,
  parameter int                     PACKET_LEN  = 4,
  parameter int                     NUM_PACKETS = 2,
  parameter logic [TDATA_WIDTH-1:0] DATA_START  = '0,
  parameter logic [TDATA_WIDTH-1:0] DATA_STEP   = TDATA_WIDTH'(1),
  parameter logic [TID_WIDTH-1:0]   TID_VALUE   = '0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable_in,
  output logic [TDATA_WIDTH-1:0]   tdata_m_out,
  output logic [TDATA_WIDTH/8:0]   tstrb_m_out,
  output logic [TDATA_WIDTH/8:0]   tkeep_m_out,
  output logic                     tlast_m_out,
  output logic [TID_WIDTH-1:0]     tid_m_out,
  output logic [TDEST_WIDTH-1:0]   tdest_m_out,
  output logic [TUSER_WIDTH-1:0]   tuser_m_out,
  output logic                     twakeup_m_out,
  output logic                     tvalid_m_out,
  input  logic                     tready_m_in,
  output logic                     done_out
);
  localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state;

  logic [BW-1:0]          beat_cnt, beat_nxt, src_beat;
  logic [31:0]            pkt_cnt, pkt_nxt, src_pkt;
  logic [TDATA_WIDTH-1:0] data_val, data_nxt, src_data;
  logic                   hs, last_beat, final_beat, load, drop, offer_ok;

`ifdef AXIS_SOURCE_RANDOM_VALID_EN
  always_ff @(posedge aclk) offer_ok <= 1'({$random} % 2);
`else
  assign offer_ok = 1'b1;
`endif

  assign hs         = tvalid_m_out && tready_m_in;
  assign last_beat  = (beat_cnt == BW'(PACKET_LEN - 1));
  assign final_beat = (NUM_PACKETS != 0) && last_beat && (pkt_cnt == 32'(NUM_PACKETS - 1));
  assign beat_nxt   = last_beat ? '0 : beat_cnt + 1'b1;
  assign pkt_nxt    = last_beat ? pkt_cnt + 32'd1 : pkt_cnt;
  assign data_nxt   = data_val + DATA_STEP;

  // A beat loaded on a handshake edge is the one after the beat just accepted.
  assign src_beat = hs ? beat_nxt : beat_cnt;
  assign src_pkt  = hs ? pkt_nxt  : pkt_cnt;
  assign src_data = hs ? data_nxt : data_val;

  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: load = enable_in && offer_ok;
      SEND: begin
        if (hs && final_beat) drop = 1'b1;
        else if (hs || !tvalid_m_out) begin
          if (enable_in && offer_ok) load = 1'b1;
          else                       drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      pkt_cnt       <= '0;
      data_val      <= DATA_START;
      tdata_m_out   <= DATA_START;
      tstrb_m_out   <= '0;
      tkeep_m_out   <= '0;
      tlast_m_out   <= 1'b0;
      tid_m_out     <= TID_VALUE;
      tdest_m_out   <= '0;
      tuser_m_out   <= '0;
      twakeup_m_out <= 1'b0;
      tvalid_m_out  <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      tid_m_out <= TID_VALUE;
      if (hs) begin
        beat_cnt <= beat_nxt;
        pkt_cnt  <= pkt_nxt;
        data_val <= data_nxt;
      end

      case (state)
        IDLE: if (enable_in) state <= SEND;
        SEND: begin
          if (hs && final_beat) begin
            state    <= DONE;
            done_out <= 1'b1;
          end else if ((hs || !tvalid_m_out) && !enable_in) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase

      if (load) begin
        tvalid_m_out  <= 1'b1;
        twakeup_m_out <= 1'b1;
        tstrb_m_out   <= '1;
        tkeep_m_out   <= '1;
        tdata_m_out   <= src_data;
        tdest_m_out   <= TDEST_WIDTH'(src_pkt);
        tuser_m_out   <= TUSER_WIDTH'(src_beat);
        tlast_m_out   <= (USE_TLAST != 0) && (src_beat == BW'(PACKET_LEN - 1));
      end else if (drop) begin
        tvalid_m_out  <= 1'b0;
        twakeup_m_out <= 1'b0;
        tstrb_m_out   <= '0;
        tkeep_m_out   <= '0;
        tlast_m_out   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_source.sv
// Directed bench: three source configurations, backpressure stability and mid-packet reset.
module tb_axi_stream_source;
  logic aclk = 1'b0;
  logic aresetn, enable, rdy0, rdy1, rdy2;

  logic [15:0] td0, td1;
  logic [7:0]  td2;
  logic [2:0]  ts0, tk0, ts1, tk1;
  logic [1:0]  ts2, tk2;
  logic [1:0]  tu0;
  logic        tl0, tl1, tl2, ti0, ti1, ti2, tde0, tde1, tde2, tu1, tu2;
  logic        tw0, tw1, tw2, tv0, tv1, tv2, dn0, dn1, dn2;

  int vectors = 0, miscompares = 0;
  int n0, n1, n2, first, last;
  logic        hold;
  logic [15:0] pd;
  logic        pde;
  logic [1:0]  pu;

  always #5 aclk = ~aclk;

  axi_stream_source #(.TUSER_WIDTH(2)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .enable_in(enable),
    .tdata_m_out(td0), .tstrb_m_out(ts0), .tkeep_m_out(tk0), .tlast_m_out(tl0),
    .tid_m_out(ti0), .tdest_m_out(tde0), .tuser_m_out(tu0), .twakeup_m_out(tw0),
    .tvalid_m_out(tv0), .tready_m_in(rdy0), .done_out(dn0));

  axi_stream_source #(.USE_TLAST(1), .PACKET_LEN(3), .NUM_PACKETS(2)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .enable_in(enable),
    .tdata_m_out(td1), .tstrb_m_out(ts1), .tkeep_m_out(tk1), .tlast_m_out(tl1),
    .tid_m_out(ti1), .tdest_m_out(tde1), .tuser_m_out(tu1), .twakeup_m_out(tw1),
    .tvalid_m_out(tv1), .tready_m_in(rdy1), .done_out(dn1));

  axi_stream_source #(.TDATA_WIDTH(8), .DATA_START(8'hFE), .NUM_PACKETS(1)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .enable_in(enable),
    .tdata_m_out(td2), .tstrb_m_out(ts2), .tkeep_m_out(tk2), .tlast_m_out(tl2),
    .tid_m_out(ti2), .tdest_m_out(tde2), .tuser_m_out(tu2), .twakeup_m_out(tw2),
    .tvalid_m_out(tv2), .tready_m_in(rdy2), .done_out(dn2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Default config: tdata k, packet index k/4, beat index k%4, no tlast.
  task automatic chk_beat0(input int k);
    chk("d0_tdata", td0, 32'(k));
    chk("d0_tdest", tde0, 32'((k / 4) % 2));
    chk("d0_tuser", tu0, 32'(k % 4));
    chk("d0_tlast", tl0, 0);
    chk("d0_tstrb", ts0, 3'b111);
    chk("d0_tkeep", tk0, 3'b111);
    chk("d0_twakeup", tw0, 1);
    chk("d0_tid", ti0, 0);
  endtask

  task automatic chk_reset0();
    chk("rst_tvalid", tv0, 0);
    chk("rst_tdata", td0, 0);
    chk("rst_tstrb", ts0, 0);
    chk("rst_tkeep", tk0, 0);
    chk("rst_tlast", tl0, 0);
    chk("rst_tdest", tde0, 0);
    chk("rst_tuser", tu0, 0);
    chk("rst_twakeup", tw0, 0);
    chk("rst_done", dn0, 0);
  endtask

  // Called at a negedge: one reset edge, check, release, advance to next negedge.
  task automatic do_reset();
    aresetn = 1'b0;
    rdy0    = 1'b1;
    @(negedge aclk);
    chk_reset0();
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (3) @(negedge aclk);
    chk_reset0();
    chk("d2_rst_tdata", td2, 32'hFE);

    // Free-running: all three configurations to completion with tready=1
    enable = 1'b1; aresetn = 1'b1;
    @(negedge aclk);
`ifndef AXIS_SOURCE_RANDOM_VALID_EN
    chk("d0_first_valid", tv0, 1);
`endif
    n0 = 0; n1 = 0; n2 = 0; first = -1; last = -1;
    for (int c = 0; c < 60 && !(dn0 && dn1 && dn2); c++) begin
      if (tv0 && rdy0) begin
        chk_beat0(n0);
        if (n0 == 0) first = c;
        last = c;
        n0++;
      end
      if (tv1 && rdy1) begin
        chk("d1_tdata", td1, 32'(n1));
        chk("d1_tlast", tl1, (n1 == 2 || n1 == 5) ? 1 : 0);
        n1++;
      end
      if (tv2 && rdy2) begin
        chk("d2_tdata", td2, 32'(8'(8'hFE + n2)));
        n2++;
      end
      @(negedge aclk);
    end
    chk("d0_beats", n0, 8);
    chk("d1_beats", n1, 6);
    chk("d2_beats", n2, 4);
    chk("d0_done", dn0, 1);
    chk("d0_tvalid_after_done", tv0, 0);
    chk("d1_done", dn1, 1);
    chk("d2_done", dn2, 1);
`ifndef AXIS_SOURCE_RANDOM_VALID_EN
    chk("d0_back_to_back", last - first, 7);
`endif

    // Random backpressure: payload frozen while tvalid && !tready
    do_reset();
    n0 = 0; hold = 1'b0; pd = '0; pde = 1'b0; pu = '0;
    for (int c = 0; c < 300 && !dn0; c++) begin
      rdy0 = 1'($urandom_range(0, 1));
      if (hold) begin
        chk("stab_tvalid", tv0, 1);
        chk("stab_tdata", td0, pd);
        chk("stab_tdest", tde0, pde);
        chk("stab_tuser", tu0, pu);
      end
      if (tv0 && rdy0) begin
        chk_beat0(n0);
        n0++;
      end
      hold = tv0 && !rdy0;
      pd = td0; pde = tde0; pu = tu0;
      @(negedge aclk);
    end
    chk("bp_beats", n0, 8);
    chk("bp_done", dn0, 1);

    // Reset after beat 5 accepted, then restart from the beginning
    do_reset();
    n0 = 0;
    for (int c = 0; c < 60 && n0 < 6; c++) begin
      if (tv0 && rdy0) begin
        chk_beat0(n0);
        n0++;
      end
      @(negedge aclk);
    end
    chk("pre_reset_beats", n0, 6);
    do_reset();
    for (int c = 0; c < 40 && !tv0; c++) @(negedge aclk);
    chk("restart_tvalid", tv0, 1);
    chk("restart_tdata", td0, 0);
    chk("restart_tdest", tde0, 0);
    chk("restart_tuser", tu0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
